// File: rtl/as_pack.sv
// Shared definitions for the as_* RV64I pipeline: field widths, the fetch
// state encoding and the layout of a buffered fetch entry.
package as_pack;

  localparam int opcode_width = 7;
  localparam int func3_width  = 3;
  localparam int instr_width  = 32;
  localparam int pc_width     = 64;

  // Fetch controller states
  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    FULL    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  // One buffered instruction together with the address it was fetched from
  typedef struct packed {
    logic [pc_width-1:0]    pc;
    logic [instr_width-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/as_fetch_fifo.sv
// Small synchronous FIFO with flush. Pointers and occupancy are reset; the
// storage array is not, since nothing reads it while the FIFO is empty.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module as_fetch_fifo
  import as_pack::*;
#(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign head_o  = mem[rd_ptr];
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  // Storage write; a flush cancels the push of the same cycle
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/as_fetch.sv
// Instruction-fetch stage for the RV64I core. Owns the fetch PC, issues one
// outstanding word request at a time to instruction memory, buffers returned
// words in as_fetch_fifo and presents the head with pre-sliced decode fields.
// Redirects flush the buffer and discard any in-flight response.
// Optional build macro AS_FETCH_MISALIGN_TRAP_EN: adds misalign_o and halts
// fetching on a redirect to a non-word-aligned target.
module as_fetch
  import as_pack::*;
#(
  parameter int                  PC_WIDTH   = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  output logic                    imem_req_o,
  output logic [PC_WIDTH-1:0]     imem_addr_o,
  input  logic                    imem_ack_i,
  input  logic [instr_width-1:0]  imem_rdata_i,
  input  logic                    redirect_i,
  input  logic [PC_WIDTH-1:0]     redirect_pc_i,
`ifdef AS_FETCH_MISALIGN_TRAP_EN
  output logic                    misalign_o,
`endif
  output logic                    instr_valid_o,
  input  logic                    instr_ready_i,
  output logic [instr_width-1:0]  instr_o,
  output logic [PC_WIDTH-1:0]     pc_o,
  output logic [opcode_width-1:0] opcode_o,
  output logic [func3_width-1:0]  func3_o,
  output logic                    func7b5_o
);

  localparam int ENTRY_W = PC_WIDTH + instr_width;

  fetch_state_t         state;
  fetch_state_t         state_nxt;
  logic [PC_WIDTH-1:0]  fetch_pc;
  logic [PC_WIDTH-1:0]  fetch_pc_nxt;
  logic [PC_WIDTH-1:0]  pending_pc;
  logic [PC_WIDTH-1:0]  pending_pc_nxt;
  logic [PC_WIDTH-1:0]  target;
  logic                 tgt_misaligned;
  logic                 misalign;
  logic                 misalign_nxt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 push;
  logic                 free;
  logic                 acc;
  logic [ENTRY_W-1:0]   head;

  // Targets are always latched word aligned so imem_addr_o never carries
  // stray low bits; the trap build only uses the low bits to flag the fault.
  assign target = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
`ifdef AS_FETCH_MISALIGN_TRAP_EN
  assign tgt_misaligned = |redirect_pc_i[1:0];
  assign misalign_o     = misalign;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb  = ^redirect_pc_i[1:0];
  assign tgt_misaligned = 1'b0;
`endif

  // A redirect wins over a pop: the head belongs to the wrong path
  assign pop  = instr_valid_o & instr_ready_i & ~redirect_i;
  assign free = ~fifo_full | pop;

  assign imem_addr_o   = fetch_pc;
  assign instr_valid_o = ~fifo_empty;
  assign instr_o       = fifo_empty ? '0 : head[instr_width-1:0];
  assign pc_o          = fifo_empty ? '0 : head[ENTRY_W-1:instr_width];
  assign opcode_o      = instr_o[6:0];
  assign func3_o       = instr_o[14:12];
  assign func7b5_o     = instr_o[30];

  as_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i ({fetch_pc, imem_rdata_i}),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Next-state, request and push decisions for the fetch controller
  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    pending_pc_nxt = pending_pc;
    misalign_nxt   = misalign;
    imem_req_o     = 1'b0;
    push           = 1'b0;
    acc            = 1'b0;

    case (state)
      BOOT:    state_nxt = FETCH;
      FETCH: begin
        imem_req_o = free & ~misalign;
        if (!free) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt = FETCH;
        end
      end
      DISCARD: imem_req_o = 1'b1;
      default: state_nxt = BOOT;
    endcase

    // An ack only counts against a request we are actually making
    acc = imem_req_o & imem_ack_i;

    if (redirect_i) begin
      misalign_nxt = tgt_misaligned;
      if (tgt_misaligned) begin
        state_nxt = FETCH;
      end else if (state == DISCARD) begin
        if (acc) begin
          fetch_pc_nxt = target;
          state_nxt    = FETCH;
        end else begin
          pending_pc_nxt = target;
        end
      end else if (imem_req_o && !imem_ack_i) begin
        // Old request still open: keep its address until the ack drains it
        pending_pc_nxt = target;
        state_nxt      = DISCARD;
      end else begin
        fetch_pc_nxt = target;
        state_nxt    = FETCH;
      end
    end else if (acc) begin
      if (state == DISCARD) begin
        fetch_pc_nxt = pending_pc;
        state_nxt    = FETCH;
      end else begin
        push         = 1'b1;
        fetch_pc_nxt = fetch_pc + PC_WIDTH'(4);
      end
    end
  end

  // Controller state, fetch PC and trap flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      misalign <= misalign_nxt;
    end
  end

  // Redirect target parked while an old request drains; only read in DISCARD
  always_ff @(posedge clk_i) begin
    pending_pc <= pending_pc_nxt;
  end

endmodule

// File: tb/tb_as_fetch.sv
// Directed bench for as_fetch: reset state, streaming fetch, back-pressure,
// slow memory, redirects (outstanding, coinciding with ack/pop), PC wrap and
// target alignment handling. Inputs change and outputs are sampled on the
// falling edge; the DUT is clocked on the rising edge.
module tb_as_fetch;
  import as_pack::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    imem_req;
  logic [63:0]             imem_addr;
  logic                    imem_ack;
  logic [31:0]             imem_rdata;
  logic                    redirect;
  logic [63:0]             redirect_pc;
  logic                    instr_valid;
  logic                    instr_ready;
  logic [31:0]             instr;
  logic [63:0]             pc;
  logic [opcode_width-1:0] opcode;
  logic [func3_width-1:0]  func3;
  logic                    func7b5;
`ifdef AS_FETCH_MISALIGN_TRAP_EN
  logic                    misalign;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Memory image: every word is an I-type ALU op tagged with its address
  function automatic logic [31:0] rd(input logic [63:0] a);
    return {a[24:0], 7'h13};
  endfunction

  always_comb imem_rdata = rd(imem_addr);

  as_fetch dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
`ifdef AS_FETCH_MISALIGN_TRAP_EN
    .misalign_o    (misalign),
`endif
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .pc_o          (pc),
    .opcode_o      (opcode),
    .func3_o       (func3),
    .func7b5_o     (func7b5)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse reset for one cycle; returns at the falling edge of the BOOT cycle
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_ready = 1'b1;
    imem_ack    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req",     imem_req,    0);
    check("rst_valid",   instr_valid, 0);
    check("rst_pc",      pc,          0);
    check("rst_instr",   instr,       0);
    check("rst_opcode",  opcode,      0);
    check("rst_func3",   func3,       0);
    check("rst_func7b5", func7b5,     0);
    rst_n = 1'b1;
    #1 check("boot_req", imem_req, 0);

    // Zero-wait streaming
    @(negedge clk);
    check("s1_req",   imem_req,    1);
    check("s1_addr",  imem_addr,   64'h0);
    check("s1_valid", instr_valid, 0);
    @(negedge clk);
    check("s2_valid",  instr_valid, 1);
    check("s2_pc",     pc,          64'h0);
    check("s2_instr",  instr,       32'h0000_0013);
    check("s2_opcode", opcode,      7'b0010011);
    check("s2_func3",  func3,       0);
    check("s2_addr",   imem_addr,   64'h4);
    @(negedge clk);
    check("s3_pc",    pc,    64'h4);
    check("s3_instr", instr, rd(64'h4));
    @(negedge clk);
    check("s4_pc", pc, 64'h8);

    // Back-pressure: fill, pop while full, FULL state, drain in order
    instr_ready = 1'b0;
    do_reset();
    @(negedge clk);
    check("bp1_addr", imem_addr, 64'h0);
    @(negedge clk);
    check("bp2_pc",  pc,        64'h0);
    check("bp2_req", imem_req,  1);
    @(negedge clk);
    check("bp3_full_req", imem_req, 0);
    check("bp3_pc",       pc,       64'h0);
    instr_ready = 1'b1;
    #1;
    check("bp3_pop_req",  imem_req,  1);
    check("bp3_pop_addr", imem_addr, 64'h8);
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    check("bp4_req", imem_req, 0);
    check("bp4_pc",  pc,       64'h4);
    @(negedge clk);
    check("bp5_fullst_req", imem_req, 0);
    check("bp5_pc",         pc,       64'h4);
    instr_ready = 1'b1;
    #1 check("bp5_pop_req", imem_req, 0);
    @(negedge clk);
    check("bp6_pc",   pc,        64'h8);
    check("bp6_req",  imem_req,  1);
    check("bp6_addr", imem_addr, 64'hC);
    @(negedge clk);
    check("bp7_pc", pc, 64'hC);

    // Slow memory: ack after three waiting cycles
    imem_ack = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("slow_req",  imem_req,  1);
      check("slow_addr", imem_addr, 64'h0);
    end
    @(negedge clk);
    imem_ack = 1'b1;
    #1 check("slow_ack_valid", instr_valid, 0);
    @(negedge clk);
    check("slow_valid", instr_valid, 1);
    check("slow_pc",    pc,          64'h0);
    @(negedge clk);
    imem_ack = 1'b0;
    check("slow_pc4",  pc,        64'h4);
    check("slow_addr8", imem_addr, 64'h8);

    // Redirect while the request to 0x8 is outstanding
    @(negedge clk);
    check("rd_empty", instr_valid, 0);
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    #1 check("rd_addr_old", imem_addr, 64'h8);
    @(negedge clk);
    redirect = 1'b0;
    check("disc_req",   imem_req,    1);
    check("disc_addr",  imem_addr,   64'h8);
    check("disc_valid", instr_valid, 0);
    imem_ack = 1'b1;
    @(negedge clk);
    check("rd_new_addr", imem_addr,   64'h100);
    check("rd_new_req",  imem_req,    1);
    check("rd_drop",     instr_valid, 0);
    @(negedge clk);
    check("rd_head_pc",    pc,    64'h100);
    check("rd_head_instr", instr, rd(64'h100));

    // Redirect coinciding with ack and pop
    redirect    = 1'b1;
    redirect_pc = 64'h40;
    @(negedge clk);
    redirect = 1'b0;
    check("co_valid", instr_valid, 0);
    check("co_addr",  imem_addr,   64'h40);
    check("co_req",   imem_req,    1);
    @(negedge clk);
    check("co_pc", pc, 64'h40);

    // PC wrap at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    check("wrap_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    check("wrap_addr0", imem_addr, 64'h0);
    check("wrap_pc",    pc,        64'hFFFF_FFFF_FFFF_FFFC);

    // Redirect to a non-word-aligned target
    redirect    = 1'b1;
    redirect_pc = 64'h102;
    @(negedge clk);
    redirect = 1'b0;
`ifdef AS_FETCH_MISALIGN_TRAP_EN
    check("mis_flag",  misalign,    1);
    check("mis_req",   imem_req,    0);
    check("mis_valid", instr_valid, 0);
    @(negedge clk);
    check("mis_hold", misalign, 1);
    check("mis_halt", imem_req, 0);
    redirect    = 1'b1;
    redirect_pc = 64'h200;
    @(negedge clk);
    redirect = 1'b0;
    check("mis_clear", misalign,  0);
    check("mis_req2",  imem_req,  1);
    check("mis_addr2", imem_addr, 64'h200);
    @(negedge clk);
    check("mis_pc2", pc, 64'h200);
`else
    check("align_addr", imem_addr, 64'h100);
    check("align_req",  imem_req,  1);
    @(negedge clk);
    check("align_pc", pc, 64'h100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
